// File: rtl/n64_controller_responder_pkg.sv
// Shared constants for the N64 controller responder: command codes, identity word,
// bit-cell timing in microseconds and the responder FSM state encoding.
package n64_controller_responder_pkg;

  localparam int DEF_TICKS_PER_US  = 50;
  localparam int DEF_TURNAROUND_US = 2;
  localparam int DEF_TIMEOUT_US    = 8;

  localparam int BIT_US      = 4;
  localparam int ONE_LOW_US  = 1;
  localparam int ZERO_LOW_US = 3;
  localparam int STOP_LOW_US = 2;
  localparam int SAMPLE_US   = 2;

  localparam logic [7:0]  CMD_STATUS = 8'h00;
  localparam logic [7:0]  CMD_POLL   = 8'h01;
  localparam logic [7:0]  CMD_RESET  = 8'hFF;
  localparam logic [23:0] ID_WORD    = {8'h05, 8'h00, 8'h02};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_RX_STOP,
    ST_DRAIN,
    ST_GAP,
    ST_TX,
    ST_TX_STOP
  } state_t;

  function automatic logic [9:0] us_ticks(input int us, input int tpu);
    return 10'(us * tpu);
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchroniser for the serial line with a registered falling-edge pulse.
module n64_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic line,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // The idle bus is pulled high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
      fall <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
      fall <= prev & ~sync;
    end
  end

  assign line = sync;

endmodule

// File: rtl/n64_controller_responder.sv
// Device-side N64 controller: decodes console commands on the open-drain line and
// answers status/reset with the identity bytes and poll with the latched button word.
module n64_controller_responder
  import n64_controller_responder_pkg::*;
#(
  parameter int TICKS_PER_US  = DEF_TICKS_PER_US,
  parameter int TURNAROUND_US = DEF_TURNAROUND_US,
  parameter int TIMEOUT_US    = DEF_TIMEOUT_US
) (
  input  logic        Clk,
  input  logic        Global_Reset,
  input  logic [31:0] Buttons,
  inout  wire         Serial_IO,
  output logic        Busy,
  output logic        Cmd_Valid,
  output logic [7:0]  Cmd,
  output logic        Rx_Error
);

  localparam logic [9:0] T_SAMPLE   = us_ticks(SAMPLE_US, TICKS_PER_US) - 10'd1;
  localparam logic [9:0] T_TIMEOUT  = us_ticks(TIMEOUT_US, TICKS_PER_US) - 10'd1;
  localparam logic [9:0] T_GAP      = us_ticks(TURNAROUND_US, TICKS_PER_US) - 10'd1;
  localparam logic [9:0] T_CELL     = us_ticks(BIT_US, TICKS_PER_US) - 10'd1;
  localparam logic [9:0] T_ONE_LOW  = us_ticks(ONE_LOW_US, TICKS_PER_US);
  localparam logic [9:0] T_ZERO_LOW = us_ticks(ZERO_LOW_US, TICKS_PER_US);
  localparam logic [9:0] T_STOP_LOW = us_ticks(STOP_LOW_US, TICKS_PER_US);
  localparam logic [9:0] T_STOP_END = us_ticks(2 * STOP_LOW_US, TICKS_PER_US) - 10'd1;

  state_t      state;
  logic [9:0]  tick;
  logic [9:0]  tick_next;
  logic [5:0]  bit_cnt;
  logic [31:0] shreg;
  logic        armed;
  logic        drive_low;
  logic        line;
  logic        fall;

  n64_line_sync u_sync (
    .clk  (Clk),
    .rst  (Global_Reset),
    .pin  (Serial_IO),
    .line (line),
    .fall (fall)
  );

  assign tick_next = tick + 10'd1;
  assign Serial_IO = drive_low ? 1'b0 : 1'bz;
  assign Busy      = (state != ST_IDLE);

  // While receiving, 'armed' means an edge was seen and its sample is still pending;
  // otherwise the tick counter is measuring the gap since the last sample for timeout.
  // The command bits are shifted into the low byte of the same register used for TX.
  always_ff @(posedge Clk or posedge Global_Reset) begin
    if (Global_Reset) begin
      state     <= ST_IDLE;
      tick      <= 10'd0;
      bit_cnt   <= 6'd0;
      shreg     <= 32'd0;
      armed     <= 1'b0;
      drive_low <= 1'b0;
      Cmd       <= 8'h00;
      Cmd_Valid <= 1'b0;
      Rx_Error  <= 1'b0;
    end else begin
      Cmd_Valid <= 1'b0;
      Rx_Error  <= 1'b0;
      tick      <= tick_next;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_RX;
            bit_cnt <= 6'd0;
            tick    <= 10'd0;
            armed   <= 1'b1;
          end
        end

        ST_RX, ST_RX_STOP: begin
          if (armed) begin
            if (tick == T_SAMPLE) begin
              tick  <= 10'd0;
              armed <= 1'b0;
              if (state == ST_RX) begin
                shreg   <= {shreg[30:0], line};
                bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt == 6'd7) state <= ST_RX_STOP;
              end else if (line) begin
                Cmd       <= shreg[7:0];
                Cmd_Valid <= 1'b1;
                case (shreg[7:0])
                  CMD_STATUS, CMD_RESET: begin
                    shreg   <= {ID_WORD, 8'h00};
                    bit_cnt <= 6'd24;
                    state   <= ST_GAP;
                  end
                  CMD_POLL: begin
                    shreg   <= Buttons;
                    bit_cnt <= 6'd32;
                    state   <= ST_GAP;
                  end
                  default: state <= ST_DRAIN;
                endcase
              end else begin
                Rx_Error <= 1'b1;
                state    <= ST_DRAIN;
              end
            end
          end else if (fall) begin
            tick  <= 10'd0;
            armed <= 1'b1;
          end else if (tick == T_TIMEOUT) begin
            Rx_Error <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (!line) begin
            tick <= 10'd0;
          end else if (tick == T_TIMEOUT) begin
            state <= ST_IDLE;
          end
        end

        ST_GAP: begin
          if (tick == T_GAP) begin
            state     <= ST_TX;
            tick      <= 10'd0;
            drive_low <= 1'b1;
          end
        end

        // drive_low is registered one cycle ahead, so it is computed from tick_next.
        ST_TX: begin
          if (tick == T_CELL) begin
            tick      <= 10'd0;
            shreg     <= {shreg[30:0], 1'b0};
            bit_cnt   <= bit_cnt - 6'd1;
            drive_low <= 1'b1;
            if (bit_cnt == 6'd1) state <= ST_TX_STOP;
          end else begin
            drive_low <= tick_next < (shreg[31] ? T_ONE_LOW : T_ZERO_LOW);
          end
        end

        ST_TX_STOP: begin
          if (tick == T_STOP_END) begin
            state <= ST_IDLE;
            tick  <= 10'd0;
          end else begin
            drive_low <= tick_next < T_STOP_LOW;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Console-side bench for n64_controller_responder: drives commands open-drain and
// decodes the responder's pulse widths back into response words.
module tb_n64_controller_responder;

  localparam int TPU = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] buttons;
  logic        console_low;
  wire         serial_io;
  logic        busy;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        rx_error;
  logic        dut_low;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  pullup (serial_io);
  assign serial_io = console_low ? 1'b0 : 1'bz;
  assign dut_low   = (serial_io === 1'b0) && !console_low;

  n64_controller_responder dut (
    .Clk          (clk),
    .Global_Reset (rst),
    .Buttons      (buttons),
    .Serial_IO    (serial_io),
    .Busy         (busy),
    .Cmd_Valid    (cmd_valid),
    .Cmd          (cmd),
    .Rx_Error     (rx_error)
  );

  // Free-running cycle count plus monitors for responder pulses and status strobes.
  int         cyc = 0;
  int         low_run = 0;
  int         pulse_q[$];
  int         first_low_cyc = 0;
  int         valid_cnt = 0;
  int         valid_cyc = 0;
  logic [7:0] valid_cmd = 8'h00;
  int         err_cnt = 0;
  int         err_cyc = 0;
  logic       both_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dut_low) begin
      if (low_run == 0 && pulse_q.size() == 0) first_low_cyc = cyc;
      low_run = low_run + 1;
    end else if (low_run != 0) begin
      pulse_q.push_back(low_run);
      low_run = 0;
    end
    if (cmd_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      valid_cmd = cmd;
    end
    if (rx_error) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (cmd_valid && rx_error) both_seen = 1'b1;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] buttons;
    int          exp_nbits;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[4];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour: which bits a well-behaved controller sends for a command.
  function automatic void model(input logic [7:0] c, input logic [31:0] btn,
                                output int nbits, output logic [31:0] word);
    if (c == 8'h00 || c == 8'hFF) begin
      nbits = 24;
      word  = 32'h0005_0002;
    end else if (c == 8'h01) begin
      nbits = 32;
      word  = btn;
    end else begin
      nbits = 0;
      word  = 32'd0;
    end
  endfunction

  task automatic hold(input logic low, input int cycles);
    console_low = low;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? TPU : 3 * TPU);
    hold(1'b0, b ? 3 * TPU : TPU);
  endtask

  task automatic send_stop();
    hold(1'b1, TPU);
    console_low = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] c, input logic [31:0] btn);
    pulse_q.delete();
    buttons = btn;
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    send_stop();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(name, {31'd0, busy}, 32'd0);
  endtask

  // Waits until the responder is driving the low part of response bit 'idx' (1-based).
  task automatic wait_tx_bit(input string name, input int idx);
    int n = 0;
    while (!(pulse_q.size() == idx - 1 && dut_low) && n < 10000) begin
      @(posedge clk); #1;
      n++;
    end
    check_output(name, {31'd0, (n < 10000)}, 32'd1);
  endtask

  task automatic decode_resp(output int nb, output logic [31:0] w,
                             output logic stop_ok, output logic bad);
    nb = 0; w = 32'd0; stop_ok = 1'b0; bad = 1'b0;
    foreach (pulse_q[i]) begin
      if (stop_ok) bad = 1'b1;
      if (pulse_q[i] >= 40 && pulse_q[i] <= 60) begin
        w = {w[30:0], 1'b1}; nb++;
      end else if (pulse_q[i] >= 140 && pulse_q[i] <= 160) begin
        w = {w[30:0], 1'b0}; nb++;
      end else if (pulse_q[i] >= 90 && pulse_q[i] <= 110) begin
        stop_ok = 1'b1;
      end else begin
        bad = 1'b1;
      end
    end
  endtask

  task automatic run_and_check(input string name, input logic [7:0] c, input logic [31:0] btn,
                               input int exp_nbits, input logic [31:0] exp_word);
    int          v0, e0, nb, lat;
    logic [31:0] w;
    logic        stop_ok, bad;
    v0 = valid_cnt;
    e0 = err_cnt;
    apply_stimulus(c, btn);
    wait_idle({name, " idle"}, 10000);
    repeat (20) @(posedge clk);
    #1;
    decode_resp(nb, w, stop_ok, bad);
    check_output({name, " valid pulses"}, 32'(valid_cnt - v0), 32'd1);
    check_output({name, " cmd"}, {24'd0, valid_cmd}, {24'd0, c});
    check_output({name, " rx errors"}, 32'(err_cnt - e0), 32'd0);
    check_output({name, " nbits"}, 32'(nb), 32'(exp_nbits));
    check_output({name, " word"}, w, exp_word);
    check_output({name, " stop"}, {31'd0, stop_ok}, {31'd0, (exp_nbits > 0)});
    check_output({name, " shape"}, {31'd0, bad}, 32'd0);
    if (exp_nbits > 0) begin
      lat = first_low_cyc - valid_cyc;
      check_output({name, " turnaround"}, {31'd0, (lat >= 97 && lat <= 103)}, 32'd1);
    end
  endtask

  initial begin
    int          nb, n, e0, v0, edge4;
    logic [31:0] w, b;
    logic [7:0]  c;
    logic        stop_ok, bad;

    vecs[0] = '{cmd: 8'h01, buttons: 32'h8000_7F81, exp_nbits: 32, exp_word: 32'h8000_7F81};
    vecs[1] = '{cmd: 8'h00, buttons: 32'hDEAD_BEEF, exp_nbits: 24, exp_word: 32'h0005_0002};
    vecs[2] = '{cmd: 8'hFF, buttons: 32'h0000_0000, exp_nbits: 24, exp_word: 32'h0005_0002};
    vecs[3] = '{cmd: 8'h03, buttons: 32'hFFFF_FFFF, exp_nbits: 0,  exp_word: 32'h0000_0000};

    rst = 1'b1;
    buttons = 32'd0;
    console_low = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_output("reset line", {31'd0, serial_io}, 32'd1);
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset cmd", {24'd0, cmd}, 32'd0);
    check_output("reset strobes", {30'd0, cmd_valid, rx_error}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].buttons,
                    vecs[i].exp_nbits, vecs[i].exp_word);

    $display("[TB] random vectors");
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h00;
        1: c = 8'h01;
        2: c = 8'hFF;
        default: c = 8'($urandom_range(2, 254));
      endcase
      b = $urandom;
      model(c, b, nb, w);
      run_and_check($sformatf("rnd%0d", i), c, b, nb, w);
    end

    $display("[TB] unsupported command drain");
    v0 = valid_cnt;
    apply_stimulus(8'h7E, 32'h1);
    n = 0;
    while (valid_cnt == v0 && n < 500) begin @(posedge clk); #1; n++; end
    check_output("drain valid", 32'(valid_cnt - v0), 32'd1);
    repeat (300) @(posedge clk);
    #1;
    check_output("drain busy held", {31'd0, busy}, 32'd1);
    wait_idle("drain release", 200);
    check_output("drain no drive", 32'(pulse_q.size()), 32'd0);

    $display("[TB] malformed stop");
    v0 = valid_cnt;
    e0 = err_cnt;
    pulse_q.delete();
    for (int i = 7; i >= 0; i--) send_bit(1'(i == 0));
    send_bit(1'b0);
    wait_idle("malformed idle", 1000);
    check_output("malformed error", 32'(err_cnt - e0), 32'd1);
    check_output("malformed valid", 32'(valid_cnt - v0), 32'd0);
    check_output("malformed no drive", 32'(pulse_q.size()), 32'd0);

    $display("[TB] timeout");
    e0 = err_cnt;
    edge4 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) edge4 = cyc;
      send_bit(1'(i % 2 == 0));
    end
    n = 0;
    while (err_cnt == e0 && n < 1000) begin @(posedge clk); #1; n++; end
    check_output("timeout error", 32'(err_cnt - e0), 32'd1);
    check_output("timeout latency", {31'd0, (err_cyc - edge4 >= 500 && err_cyc - edge4 <= 508)}, 32'd1);
    check_output("timeout idle", {31'd0, busy}, 32'd0);
    b = $urandom;
    model(8'h01, b, nb, w);
    run_and_check("post-timeout poll", 8'h01, b, nb, w);

    $display("[TB] tear protection");
    apply_stimulus(8'h01, 32'h1234_5678);
    wait_tx_bit("tear reach bit10", 10);
    buttons = 32'hFFFF_FFFF;
    wait_idle("tear idle", 10000);
    repeat (5) @(posedge clk);
    #1;
    decode_resp(nb, w, stop_ok, bad);
    check_output("tear word", w, 32'h1234_5678);

    $display("[TB] reset mid-transmit");
    apply_stimulus(8'h01, 32'h0F0F_0F0F);
    wait_tx_bit("reset reach bit20", 20);
    rst = 1'b1;
    #1;
    check_output("reset mid-tx line", {31'd0, serial_io}, 32'd1);
    check_output("reset mid-tx busy", {31'd0, busy}, 32'd0);
    check_output("reset mid-tx cmd", {24'd0, cmd}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;

    check_output("valid/error exclusive", {31'd0, both_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
